// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg: shared widths and arithmetic helpers for adc_input_conditioner.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: default widths, offset-binary to signed conversion, saturating narrow
// (signed OUT_W+1 -> OUT_W with a clip flag).
package adc_cond_pkg;

  localparam int ADC_IN_W       = 12;
  localparam int ADC_OUT_W      = 16;
  localparam int ADC_DECIM_LOG2 = 2;
  localparam int ADC_DC_SHIFT   = 10;

  // Offset binary -> signed. Subtracting half scale is the same as inverting
  // the MSB and reading the code as two's complement; the result comes back
  // already sign-extended to 64 bits.
  function automatic longint ob_to_signed(input longint code, input int in_w);
    return code - (longint'(1) <<< (in_w - 1));
  endfunction

  // Clamp a signed value to the range of an out_w-bit two's complement word.
  // clipped reports whether clamping happened.
  function automatic longint sat_narrow(input longint v, input int out_w,
                                        output logic clipped);
    longint hi;
    longint lo;
    longint r;
    hi      = (longint'(1) <<< (out_w - 1)) - 1;
    lo      = -hi - 1;
    clipped = 1'b0;
    r       = v;
    if (v > hi) begin
      r       = hi;
      clipped = 1'b1;
    end else if (v < lo) begin
      r       = lo;
      clipped = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_input_conditioner_if.sv
// adc_input_conditioner_if: sample-in / result-out bundle of the ADC conditioner.
// Latency: n/a (wires only).
// Backpressure: input side has none; output side is valid/ready with overwrite.
// slave modport = conditioner view, master modport = ADC/consumer side view.
interface adc_input_conditioner_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic [IN_W-1:0]  in_sample;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_sample;
  logic             overrun;
  logic             clip;

  modport master (
    output in_valid, in_sample, out_ready,
    input  out_valid, out_sample, overrun, clip
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output out_valid, out_sample, overrun, clip
  );
endinterface

// File: rtl/adc_input_conditioner_dc_blocker.sv
// dc_blocker: leaky-integrator DC removal, subtract and saturate (ADC_COND_DC_BLOCK_EN builds).
// Latency: 0 cycles avg_in -> y_out (combinational); dc_est updates on avg_valid.
// Backpressure: none; every avg_valid is consumed.
// Ports: clk, rst (async, active-high), avg_valid/avg_in in, y_valid/y_out/clip out.
module dc_blocker
  import adc_cond_pkg::*;
#(
  parameter int OUT_W    = ADC_OUT_W,
  parameter int DC_SHIFT = ADC_DC_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    avg_valid,
  input  logic signed [OUT_W-1:0] avg_in,
  output logic                    y_valid,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    clip
);

  localparam int DC_W = OUT_W + DC_SHIFT;

  logic signed [DC_W-1:0]  dc_est;
  logic signed [OUT_W-1:0] est;
  logic signed [OUT_W:0]   diff;
  logic                    clip_c;

  // Arithmetic shift floors, so a negative estimate rounds toward -inf.
  assign est  = OUT_W'(dc_est >>> DC_SHIFT);
  assign diff = (OUT_W+1)'(avg_in) - (OUT_W+1)'(est);

  always_comb begin
    clip_c = 1'b0;
    y_out  = OUT_W'(sat_narrow(longint'(diff), OUT_W, clip_c));
  end

  assign y_valid = avg_valid;
  assign clip    = avg_valid && clip_c;

  // The integrator tracks the unsaturated difference so a clipped step does
  // not slow down convergence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_est <= '0;
    end else if (avg_valid) begin
      dc_est <= dc_est + DC_W'(diff);
    end
  end

endmodule

// File: rtl/adc_input_conditioner.sv
// adc_input_conditioner: offset-binary ADC samples -> signed, scaled, block-averaged, optional DC removal.
// Latency: 2 cycles from the window-completing sample to out_valid.
// Backpressure: none on input; an unconsumed result is overwritten and overrun pulses.
// Ports: clk, rst (async, active-high), bus (adc_input_conditioner_if.slave).
// Optional: define ADC_COND_DC_BLOCK_EN to enable the dc_blocker stage; otherwise y = avg, clip = 0.
module adc_input_conditioner
  import adc_cond_pkg::*;
#(
  parameter int IN_W       = ADC_IN_W,
  parameter int OUT_W      = ADC_OUT_W,
  parameter int DECIM_LOG2 = ADC_DECIM_LOG2,
  parameter int DC_SHIFT   = ADC_DC_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  adc_input_conditioner_if.slave bus
);

  localparam int ACC_W = OUT_W + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DECIM_LOG2) - 1);

  if (OUT_W < IN_W || DC_SHIFT < 1) begin : g_param_chk
    $error("adc_input_conditioner: OUT_W must be >= IN_W and DC_SHIFT >= 1");
  end

  // ---------------- input conversion ----------------
  logic signed [OUT_W-1:0] s;
  assign s = OUT_W'(ob_to_signed(longint'(bus.in_sample), IN_W) <<< (OUT_W - IN_W));

  // ---------------- averaging / decimation ----------------
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    avg_vld;
  logic signed [OUT_W-1:0] avg;

  assign sum = acc + ACC_W'(s);

  // With DECIM_LOG2 = 0, CNT_MAX is 0 and cnt never leaves 0, so every
  // accepted sample closes a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      avg_vld <= 1'b0;
      avg     <= '0;
    end else begin
      avg_vld <= bus.in_valid && (cnt == CNT_MAX);
      if (bus.in_valid) begin
        if (cnt == CNT_MAX) begin
          acc <= '0;
          cnt <= '0;
          avg <= OUT_W'(sum >>> DECIM_LOG2);
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- DC removal (combinational into output register) ----------------
  logic                    y_vld;
  logic signed [OUT_W-1:0] y;
  logic                    y_clip;

`ifdef ADC_COND_DC_BLOCK_EN
  dc_blocker #(
    .OUT_W    (OUT_W),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk       (clk),
    .rst       (rst),
    .avg_valid (avg_vld),
    .avg_in    (avg),
    .y_valid   (y_vld),
    .y_out     (y),
    .clip      (y_clip)
  );
`else
  assign y_vld  = avg_vld;
  assign y      = avg;
  assign y_clip = 1'b0;
`endif

  // ---------------- output register ----------------
  logic             out_valid_q;
  logic [OUT_W-1:0] out_sample_q;
  logic             overrun_q;
  logic             clip_q;

  // A new result always wins: it overwrites a held value (overrun) unless the
  // consumer takes the old one in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      clip_q <= y_vld && y_clip;
      if (y_vld) begin
        out_sample_q <= y;
        out_valid_q  <= 1'b1;
        overrun_q    <= out_valid_q && !bus.out_ready;
      end else begin
        overrun_q <= 1'b0;
        if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.overrun    = overrun_q;
  assign bus.clip       = clip_q;

endmodule
